// File: rtl/receive_engine.sv
// rtl/receive_engine.sv - UART receive engine: 7/8-bit frames, optional parity, rxrdy/read handshake
// Optional build macro RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
`timescale 1ns/1ps

module receive_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx,
  input  logic       read,
  output logic       rxrdy,
  output logic [7:0] in_port,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  logic [18:0] r_cnt;
  logic [18:0] r_bit_time;
  logic        r_eight;
  logic        r_par_en;
  logic        r_odd;
  logic [7:0]  r_shift;
  logic [2:0]  r_nbits;
  logic        r_par_bit;
  logic        r_stop_bit;
  logic        r_rxrdy;
  logic [7:0]  r_in_port;
  logic        r_perr;
  logic        r_ferr;
  logic        r_ovf;

  logic        w_bit;
  logic [7:0]  w_data;
  logic [18:0] w_half_m1;
  logic [18:0] w_full_m1;
  logic        w_full_hit;
  logic [2:0]  w_last_bit;

  function automatic logic [18:0] f_bit_time(input logic [3:0] sel);
    case (sel)
      4'd0:    f_bit_time = 19'd333333;
      4'd1:    f_bit_time = 19'd83333;
      4'd2:    f_bit_time = 19'd41667;
      4'd3:    f_bit_time = 19'd20833;
      4'd4:    f_bit_time = 19'd10417;
      4'd5:    f_bit_time = 19'd5208;
      4'd6:    f_bit_time = 19'd2604;
      4'd7:    f_bit_time = 19'd1736;
      4'd8:    f_bit_time = 19'd868;
      4'd9:    f_bit_time = 19'd434;
      4'd10:   f_bit_time = 19'd217;
      default: f_bit_time = 19'd109;
    endcase
  endfunction

`ifdef RX_MAJORITY_EN
  // Vote over the last three synchronized samples; the decision lands on the newest one.
  logic r_rx_prev2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_prev2 <= 1'b1;
    else        r_rx_prev2 <= r_rx_prev;
  end
  assign w_bit = (r_rx_sync & r_rx_prev) | (r_rx_sync & r_rx_prev2) | (r_rx_prev & r_rx_prev2);
`else
  assign w_bit = r_rx_sync;
`endif

  assign w_half_m1  = (r_bit_time >> 1) - 19'd1;
  assign w_full_m1  = r_bit_time - 19'd1;
  assign w_full_hit = (r_cnt == w_full_m1);
  assign w_last_bit = r_eight ? 3'd7 : 3'd6;
  // 7-bit frames leave the data in the upper seven shift positions.
  assign w_data     = r_eight ? r_shift : {1'b0, r_shift[7:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_cnt      <= '0;
      r_bit_time <= 19'd109;
      r_eight    <= 1'b1;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_shift    <= '0;
      r_nbits    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_bit <= 1'b1;
      r_rxrdy    <= 1'b0;
      r_in_port  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;

      if (read) begin
        r_rxrdy <= 1'b0;
        r_ovf   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Only a real high-to-low transition starts a frame, so a held-low break is ignored.
          if (r_rx_prev && !r_rx_sync) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bit_time <= f_bit_time(baud);
            r_eight    <= eight;
            r_par_en   <= parity_en;
            r_odd      <= odd_n_even;
          end
        end
        S_START: begin
          if (r_cnt == w_half_m1) begin
            r_cnt   <= '0;
            r_nbits <= '0;
            r_state <= w_bit ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_DATA: begin
          if (w_full_hit) begin
            r_cnt   <= '0;
            r_shift <= {w_bit, r_shift[7:1]};
            r_nbits <= r_nbits + 3'd1;
            if (r_nbits == w_last_bit)
              r_state <= r_par_en ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_PARITY: begin
          if (w_full_hit) begin
            r_cnt     <= '0;
            r_par_bit <= w_bit;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_STOP: begin
          if (w_full_hit) begin
            r_cnt      <= '0;
            r_stop_bit <= w_bit;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_DONE: begin
          // A coinciding read is overridden here: the new byte stays pending and no overrun is flagged.
          r_in_port <= w_data;
          r_perr    <= r_par_en & (^w_data ^ r_par_bit ^ r_odd);
          r_ferr    <= ~r_stop_bit;
          r_rxrdy   <= 1'b1;
          if (r_rxrdy && !read)
            r_ovf <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rxrdy   = r_rxrdy;
  assign in_port = r_in_port;
  assign perr    = r_perr;
  assign ferr    = r_ferr;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_receive_engine.sv
// tb/tb_receive_engine.sv - self-checking bench for receive_engine with a behavioural frame model
`timescale 1ns/1ps

module tb_receive_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] baud = 4'b1011;
  logic       eight = 1'b1;
  logic       parity_en = 1'b1;
  logic       odd_n_even = 1'b1;
  logic       rx = 1'b1;
  logic       read = 1'b0;
  logic       rxrdy;
  logic [7:0] in_port;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int n_pass = 0;
  int n_checks = 0;
  int btab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217,
                    109, 109, 109, 109, 109};

  receive_engine dut (
    .clk(clk), .reset(reset), .baud(baud), .eight(eight), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .rx(rx), .read(read), .rxrdy(rxrdy), .in_port(in_port),
    .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Leaves rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic pbit, input logic sbit, input int bt);
    rx = 1'b0;
    #(bt * 10);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      #(bt * 10);
    end
    if (has_par) begin
      rx = pbit;
      #(bt * 10);
    end
    rx = sbit;
    #(bt * 10);
  endtask

  task automatic pulse_read();
    @(negedge clk) read = 1'b1;
    @(negedge clk) read = 1'b0;
  endtask

  function automatic logic model_perr(input logic [7:0] d, input int nbits, input logic pen,
                                      input logic pbit, input logic odd);
    int ones;
    ones = pbit;
    for (int i = 0; i < nbits; i++) ones += d[i];
    return pen && ((ones % 2) != int'(odd));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr, ovf} !== 12'h0)
      $display("FAIL reset_values got %h exp %h", {rxrdy, in_port, perr, ferr, ovf}, 12'h0);
    else n_pass++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    baud = 4'b1011; eight = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
    rx = 1'b0;
    #(109 * 10);
    rx = 1'b1;
    #(109 * 5);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr, ovf} !== 12'h0)
      $display("FAIL reset_mid_frame got %h exp %h", {rxrdy, in_port, perr, ferr, ovf}, 12'h0);
    else n_pass++;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #(109 * 20);
    @(posedge clk); #2;
    send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr, ovf} !== {1'b1, 8'h0F, 3'b000})
      $display("FAIL clean_after_reset got %h exp %h", {rxrdy, in_port, perr, ferr, ovf},
               {1'b1, 8'h0F, 3'b000});
    else n_pass++;
    pulse_read();
  endtask

  task automatic test_parity();
    int lat;
    @(posedge clk); #2;
    fork
      send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 109);
      begin
        lat = 0;
        while (!rxrdy && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_checks++;
    if (lat < 1140 || lat > 1160)
      $display("FAIL rx_latency got %0d clocks exp 1140..1160", lat);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({in_port, perr, ferr} !== {8'h0F, 2'b00})
      $display("FAIL parity_ok got %h exp %h", {in_port, perr, ferr}, {8'h0F, 2'b00});
    else n_pass++;
    pulse_read();
    send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if ({in_port, perr, ferr} !== {8'h0F, 2'b10})
      $display("FAIL parity_bad got %h exp %h", {in_port, perr, ferr}, {8'h0F, 2'b10});
    else n_pass++;
    pulse_read();
  endtask

  task automatic test_framing_break();
    send_frame(8'h55, 8, 1'b1, 1'b1, 1'b0, 109);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr} !== {1'b1, 8'h55, 2'b01})
      $display("FAIL framing_err got %h exp %h", {rxrdy, in_port, perr, ferr}, {1'b1, 8'h55, 2'b01});
    else n_pass++;
    pulse_read();
    #(109 * 30);
    n_checks++;
    if (rxrdy !== 1'b0)
      $display("FAIL break_no_retrigger got %b exp 0", rxrdy);
    else n_pass++;
    rx = 1'b1;
    #(109 * 20);
    send_frame(8'hC3, 8, 1'b1, 1'b1, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr} !== {1'b1, 8'hC3, 2'b00})
      $display("FAIL after_break got %h exp %h", {rxrdy, in_port, perr, ferr}, {1'b1, 8'hC3, 2'b00});
    else n_pass++;
    pulse_read();
  endtask

  task automatic test_seven_bit();
    eight = 1'b0; parity_en = 1'b0;
    send_frame(8'h7F, 7, 1'b0, 1'b0, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, perr, ferr} !== {1'b1, 8'h7F, 2'b00})
      $display("FAIL seven_bit got %h exp %h", {rxrdy, in_port, perr, ferr}, {1'b1, 8'h7F, 2'b00});
    else n_pass++;
    pulse_read();
    send_frame(8'h2A, 7, 1'b0, 1'b0, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if (in_port !== 8'h2A)
      $display("FAIL seven_bit_b got %h exp %h", in_port, 8'h2A);
    else n_pass++;
    pulse_read();
    eight = 1'b1;
  endtask

  task automatic test_overrun();
    parity_en = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 109);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 109);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port, ovf} !== {1'b1, 8'h3C, 1'b1})
      $display("FAIL overrun got %h exp %h", {rxrdy, in_port, ovf}, {1'b1, 8'h3C, 1'b1});
    else n_pass++;
    pulse_read();
    n_checks++;
    if ({rxrdy, ovf} !== 2'b00)
      $display("FAIL read_clears got %b exp 00", {rxrdy, ovf});
    else n_pass++;
  endtask

  task automatic test_read_at_done();
    int k;
    @(posedge clk); #2;
    fork
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 109);
      begin
        k = 0;
        while (!rxrdy && k < 3000) begin
          @(negedge clk);
          k++;
        end
      end
    join
    n_checks++;
    if (k >= 3000) begin
      $display("FAIL done_timeout got %0d exp <3000", k);
    end else begin
      n_pass++;
      @(posedge clk); #2;
      fork
        send_frame(8'h69, 8, 1'b0, 1'b0, 1'b1, 109);
        begin
          repeat (k - 1) @(negedge clk);
          read = 1'b1;
          @(negedge clk);
          read = 1'b0;
          n_checks++;
          if ({rxrdy, ovf, in_port} !== {2'b10, 8'h69})
            $display("FAIL read_at_done got %h exp %h", {rxrdy, ovf, in_port}, {2'b10, 8'h69});
          else n_pass++;
        end
      join
    end
    pulse_read();
  endtask

  task automatic test_glitch();
    @(posedge clk); #2;
    rx = 1'b0;
    #300;
    rx = 1'b1;
    repeat (400) @(negedge clk);
    n_checks++;
    if (rxrdy !== 1'b0)
      $display("FAIL false_start got %b exp 0", rxrdy);
    else n_pass++;
  endtask

`ifdef RX_MAJORITY_EN
  task automatic test_majority_spike();
    eight = 1'b1; parity_en = 1'b0; baud = 4'b1011;
    @(posedge clk); #2;
    rx = 1'b0;
    #(109 * 10);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 109; c++) begin
        rx = (c % 3 == 1);
        #10;
      end
    rx = 1'b1;
    #(109 * 10);
    @(negedge clk);
    n_checks++;
    if ({rxrdy, in_port} !== {1'b1, 8'h00})
      $display("FAIL majority_spike got %h exp %h", {rxrdy, in_port}, {1'b1, 8'h00});
    else n_pass++;
    pulse_read();
  endtask
`endif

  task automatic test_random();
    logic [7:0] d, dm;
    logic e, pe, od, pb, sb, ep;
    int bt, nb;
    for (int t = 0; t < 12; t++) begin
      baud = 4'($urandom_range(10, 15));
      e = 1'($urandom); pe = 1'($urandom); od = 1'($urandom); pb = 1'($urandom);
      sb = ($urandom % 4) != 0;
      d = 8'($urandom);
      eight = e; parity_en = pe; odd_n_even = od;
      bt = btab[baud];
      nb = e ? 8 : 7;
      dm = e ? d : (d & 8'h7F);
      ep = model_perr(dm, nb, pe, pb, od);
      send_frame(d, nb, pe, pb, sb, bt);
      rx = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rxrdy, in_port, perr, ferr, ovf} !== {1'b1, dm, ep, ~sb, 1'b0})
        $display("FAIL random_%0d got %h exp %h", t, {rxrdy, in_port, perr, ferr, ovf},
                 {1'b1, dm, ep, ~sb, 1'b0});
      else n_pass++;
      pulse_read();
      #(bt * 20);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_parity();
    test_framing_break();
    test_seven_bit();
    test_overrun();
    test_read_at_done();
    test_glitch();
`ifdef RX_MAJORITY_EN
    test_majority_spike();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
